online_mul_sequencer: RTL and testbench
=======================================

// Module: online_mul_sequencer
// PURPOSE
// - Sequences the online multiplier's upper-bits control datapath through one full operation:
//   online-delay warm-up, N digit iterations and zero-digit flush.
// - Drives the two-phase register enables (enable_upper, then enable_v_reg) and the shift_in digit.
// - Emits result digits p_j over a valid/ready handshake and reports busy/done to the top level.
// PARAMETERS
// - N_DIGITS  16  operand/result length in signed digits
// - DELTA     3   online delay; no result digits are emitted for iterations j < DELTA
// - CNT_W     $clog2(N_DIGITS+DELTA+1)  width of the iteration counter
// PORTS
// - clk            in   1      clock, rising edge
// - asyn_reset     in   1      asynchronous, active-high reset
// - start          in   1      single-cycle request; sampled only in IDLE
// - busy           out  1      high from the cycle after start is accepted until DONE, inclusive
// - done           out  1      one-cycle pulse in DONE
// - dp_clear       out  1      one-cycle pulse on start acceptance; clears datapath state
// - in_digit       in   2      input digit {plus,minus}
// - in_valid       in   1      in_digit valid
// - in_ready       out  1      high in LOAD while j < N_DIGITS
// - shift_in       out  2      to datapath: in_digit when j < N_DIGITS, else 2'b00
// - enable_upper   out  1      phase A enable (latch w_stored)
// - enable_v_reg   out  1      phase B enable (transfer to res)
// - p_value        in   2      selected digit from the datapath (+1=10, 0=00, -1=01)
// - out_digit      out  2      registered result digit
// - out_valid      out  1      out_digit valid; held until out_ready
// - out_ready      in   1      consumer accepts out_digit
// - iter_idx       out  CNT_W  current iteration j
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, j=0; every output 0 (busy, done, dp_clear, in_ready,
//   enable_upper, enable_v_reg, out_valid, shift_in, out_digit, iter_idx).
// - FSM states: IDLE, LOAD, UPDATE, EMIT, DONE.
// - IDLE: start=1 -> dp_clear=1 this cycle, j<=0, go LOAD. start=0 -> stay. Never any enable.
// - LOAD, j < N_DIGITS: in_ready=1; on in_valid&&in_ready: enable_upper=1, shift_in=in_digit,
//   capture p_value into out_digit, go UPDATE; otherwise stall with all enables 0.
// - LOAD, j >= N_DIGITS: in_ready=0, shift_in=00, enable_upper=1 unconditionally, capture p_value,
//   go UPDATE.
// - enable_upper is combinational from state/handshake; shift_in is 00 whenever enable_upper=0.
// - UPDATE: enable_v_reg=1 for exactly one cycle. Then: j>=DELTA -> EMIT; else j<=j+1, go LOAD.
// - EMIT: out_valid=1, out_digit stable. On out_ready: if j == N_DIGITS+DELTA-1 -> DONE,
//   else j<=j+1, go LOAD. out_ready=0 -> stall (no enables, out_digit/out_valid held).
// - DONE: done=1, busy=1 for one cycle, then IDLE.
// - Per operation: exactly N_DIGITS+DELTA enable_upper pulses, the same number of enable_v_reg
//   pulses, each enable_v_reg exactly one cycle after its enable_upper; N_DIGITS input
//   handshakes; N_DIGITS output handshakes.
// - Minimum latency with no stalls: 2 cycles per warm-up iteration, 3 per emitting iteration;
//   total 2*DELTA+3*N_DIGITS cycles from start acceptance to DONE.
// - start while busy: ignored (no restart, no dp_clear). in_valid outside LOAD: ignored.
// - enable_upper and enable_v_reg are never high in the same cycle.
// - Counter never wraps; j saturates at N_DIGITS+DELTA-1.
// STRUCTURE
// - Shared package online_pkg: state enum (IDLE/LOAD/UPDATE/EMIT/DONE), digit constants
//   DIG_POS=2'b10, DIG_ZERO=2'b00, DIG_NEG=2'b01.
// - Single flat module; no sub-module (FSM + counter + one output register).
// TESTING (N_DIGITS=4, DELTA=2)
// - No stalls, in_valid=1, out_ready=1: start -> done after 2*2+3*4=16 cycles; 6 enable_upper,
//   6 enable_v_reg pulses; 4 in handshakes; 4 out handshakes on j=2..5.
// - Stub p_value=10 constant -> out_digit=10 on every out_valid; shift_in=00 for j=4,5.
// - in_valid low 3 cycles in LOAD at j=1 -> no enables during stall; total length +3 cycles.
// - out_ready low 5 cycles at j=3 EMIT -> out_valid/out_digit held, no enables; total +5 cycles.
// - start pulsed at j=2 while busy -> ignored, no dp_clear, count of pulses unchanged.
// - asyn_reset asserted in UPDATE at j=3 -> all outputs 0 immediately; next start runs a full
//   clean operation with dp_clear=1.

Source files
------------

// File: rtl/online_pkg.sv
// online_pkg: shared FSM state encoding and signed-digit constants for the online multiplier
package online_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, UPDATE, EMIT, DONE} state_t;

   localparam logic [1:0] DIG_POS  = 2'b10;
   localparam logic [1:0] DIG_ZERO = 2'b00;
   localparam logic [1:0] DIG_NEG  = 2'b01;

endpackage

// File: rtl/online_mul_sequencer.sv
// online_mul_sequencer: drives warm-up, digit iterations and zero flush of the online multiplier
module online_mul_sequencer
   import online_pkg::*;
#(
   parameter int N_DIGITS = 16,
   parameter int DELTA    = 3,
   parameter int CNT_W    = $clog2(N_DIGITS + DELTA + 1)
) (
   input  logic             clk,
   input  logic             asyn_reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             dp_clear,
   input  logic [1:0]       in_digit,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [1:0]       shift_in,
   output logic             enable_upper,
   output logic             enable_v_reg,
   input  logic [1:0]       p_value,
   output logic [1:0]       out_digit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] iter_idx
);

   localparam logic [CNT_W-1:0] N_LIM = CNT_W'(N_DIGITS);
   localparam logic [CNT_W-1:0] D_LIM = CNT_W'(DELTA);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_DIGITS + DELTA - 1);

   state_t           state;
   logic [CNT_W-1:0] j;
   logic             feeding;

   // Handshake and enable decode; the flush iterations (j >= N_DIGITS) fire without an input digit
   always_comb begin
      feeding      = j < N_LIM;
      in_ready     = (state == LOAD) && feeding;
      enable_upper = (state == LOAD) && (!feeding || in_valid);
      shift_in     = (enable_upper && feeding) ? in_digit : DIG_ZERO;
      enable_v_reg = state == UPDATE;
      out_valid    = state == EMIT;
      done         = state == DONE;
      busy         = state != IDLE;
      dp_clear     = (state == IDLE) && start && !asyn_reset;
      iter_idx     = j;
   end

   // Operation FSM with iteration counter; p_value is captured alongside each phase-A enable
   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
         state     <= IDLE;
         j         <= '0;
         out_digit <= DIG_ZERO;
      end else begin
         case (state)
            IDLE:
               if (start) begin
                  j     <= '0;
                  state <= LOAD;
               end
            LOAD:
               if (enable_upper) begin
                  out_digit <= p_value;
                  state     <= UPDATE;
               end
            UPDATE:
               if (j >= D_LIM) state <= EMIT;
               else begin
                  j     <= j + 1'b1;
                  state <= LOAD;
               end
            EMIT:
               if (out_ready) begin
                  if (j == LAST) state <= DONE;
                  else begin
                     j     <= j + 1'b1;
                     state <= LOAD;
                  end
               end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_online_mul_sequencer.sv
// tb_online_mul_sequencer: scoreboard bench for the online multiplier sequencer (N_DIGITS=4, DELTA=2)
module tb_online_mul_sequencer;

   localparam int N = 4;
   localparam int D = 2;
   localparam int W = $clog2(N + D + 1);

   logic         clk = 0, asyn_reset = 1, start = 0, in_valid = 0, out_ready = 0, use_tab = 0;
   logic [1:0]   in_digit, p_value, shift_in, out_digit;
   logic         busy, done, dp_clear, in_ready, enable_upper, enable_v_reg, out_valid;
   logic [W-1:0] iter_idx;

   logic [1:0] in_tab [4] = '{2'b10, 2'b01, 2'b00, 2'b10};
   logic [1:0] p_tab  [8] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};

   assign in_digit = (iter_idx < W'(N)) ? in_tab[iter_idx[1:0]] : 2'b11;
   assign p_value  = use_tab ? p_tab[iter_idx] : 2'b10;

   online_mul_sequencer #(.N_DIGITS(N), .DELTA(D)) dut (
      .clk(clk), .asyn_reset(asyn_reset), .start(start), .busy(busy), .done(done),
      .dp_clear(dp_clear), .in_digit(in_digit), .in_valid(in_valid), .in_ready(in_ready),
      .shift_in(shift_in), .enable_upper(enable_upper), .enable_v_reg(enable_v_reg),
      .p_value(p_value), .out_digit(out_digit), .out_valid(out_valid), .out_ready(out_ready),
      .iter_idx(iter_idx)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0, total = 0;
   int n_eu, n_ev, n_in, n_out, n_dp, n_done;
   logic [1:0] q_shift [$];
   logic [1:0] q_out [$];
   int         q_idx [$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Monitor: pops the scoreboard on every enable/handshake and checks cycle-to-cycle invariants
   logic       prev_eu = 0, prev_ov = 0, prev_or = 0;
   logic [1:0] prev_od = 0;
   always @(negedge clk) begin
      if (asyn_reset) begin
         prev_eu = 0; prev_ov = 0; prev_or = 0;
      end else begin
         if (enable_upper || enable_v_reg) chk("no_overlap", int'(enable_upper & enable_v_reg), 0);
         if (enable_v_reg || prev_eu) chk("v_after_u", int'(enable_v_reg), int'(prev_eu));
         if (in_ready && !in_valid) chk("in_stall_quiet", int'({enable_upper, enable_v_reg, shift_in}), 0);
         if (prev_ov && !prev_or) begin
            chk("ov_held", int'(out_valid), 1);
            chk("od_held", int'(out_digit), int'(prev_od));
            chk("out_stall_quiet", int'({enable_upper, enable_v_reg}), 0);
         end
         if (enable_upper) begin
            n_eu++;
            if (q_shift.size() == 0) chk("shift_q_empty", 1, 0);
            else chk("shift_in", int'(shift_in), int'(q_shift.pop_front()));
         end
         if (enable_v_reg) n_ev++;
         if (in_valid && in_ready) n_in++;
         if (dp_clear) n_dp++;
         if (done) n_done++;
         if (out_valid && out_ready) begin
            n_out++;
            if (q_out.size() == 0) chk("out_q_empty", 1, 0);
            else begin
               chk("out_digit", int'(out_digit), int'(q_out.pop_front()));
               chk("out_iter", int'(iter_idx), q_idx.pop_front());
            end
         end
         prev_eu = enable_upper; prev_ov = out_valid; prev_or = out_ready; prev_od = out_digit;
      end
   end

   task automatic push_exp(input logic tab);
      for (int k = 0; k < N + D; k++) q_shift.push_back(k < N ? in_tab[k] : 2'b00);
      for (int k = D; k < N + D; k++) begin
         q_out.push_back(tab ? p_tab[k] : 2'b10);
         q_idx.push_back(k);
      end
   endtask

   task automatic run_op(input int sin, input int sout, input bit mid, input logic tab);
      int cyc = 0, in_left = sin, out_left = sout;
      bit fired = 0;
      n_eu = 0; n_ev = 0; n_in = 0; n_out = 0; n_dp = 0; n_done = 0;
      use_tab = tab;
      push_exp(tab);
      start = 1; in_valid = 1; out_ready = 1;
      @(posedge clk); #1;
      start = 0;
      while (!done && cyc < 200) begin
         if (in_ready && iter_idx == 1 && in_left > 0) begin in_valid = 0; in_left--; end
         else in_valid = 1;
         if (out_valid && iter_idx == 3 && out_left > 0) begin out_ready = 0; out_left--; end
         else out_ready = 1;
         if (mid && !fired && busy && iter_idx == 2) begin start = 1; fired = 1; end
         else start = 0;
         @(posedge clk); #1;
         cyc++;
      end
      start = 0;
      chk("latency", cyc, 2 * D + 3 * N + sin + sout);
      @(posedge clk); #1;
      chk("eu_pulses", n_eu, N + D);
      chk("ev_pulses", n_ev, N + D);
      chk("in_hs", n_in, N);
      chk("out_hs", n_out, N);
      chk("dp_clear", n_dp, 1);
      chk("done_pulses", n_done, 1);
      chk("sb_empty", q_shift.size() + q_out.size(), 0);
      chk("idle_busy", int'(busy), 0);
   endtask

   function automatic int all_outs();
      return int'({busy, done, dp_clear, in_ready, enable_upper, enable_v_reg, out_valid,
                   shift_in, out_digit, iter_idx});
   endfunction

   initial begin
      #3;
      chk("reset_outs", all_outs(), 0);
      @(posedge clk); #1;
      asyn_reset = 0;
      @(posedge clk); #1;
      chk("idle_outs", all_outs(), 0);
      run_op(0, 0, 0, 0);
      run_op(3, 0, 0, 1);
      run_op(0, 5, 0, 1);
      run_op(0, 0, 1, 1);
      begin
         int cyc = 0;
         push_exp(1);
         use_tab = 1; start = 1; in_valid = 1; out_ready = 1;
         @(posedge clk); #1;
         start = 0;
         while (!(enable_v_reg && iter_idx == 3) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk("reach_update3", int'(enable_v_reg && iter_idx == 3), 1);
         #2 asyn_reset = 1;
         #1 chk("async_reset_outs", all_outs(), 0);
         @(posedge clk); #1;
         asyn_reset = 0;
         q_shift.delete(); q_out.delete(); q_idx.delete();
         @(posedge clk); #1;
      end
      run_op(0, 0, 0, 1);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
